// File: rtl/leb128_pkg.sv
// -----------------------------------------------------------------------------
// leb128_pkg
// Shared constants for the LEB128 immediate decoder: maximum encoded lengths
// for 32/64-bit targets, the index of the last legal byte, the decoder state
// encodings and a helper that picks the last legal byte index for a mode.
// -----------------------------------------------------------------------------
package leb128_pkg;

  localparam int LEB_DATA_W       = 64;
  localparam int LEB_MAX_BYTES_32 = 5;
  localparam int LEB_MAX_BYTES_64 = 10;

  // 0-based index of the final byte a legal encoding may occupy.
  localparam logic [3:0] LEB_LAST_IDX_32 = 4'(LEB_MAX_BYTES_32 - 1);
  localparam logic [3:0] LEB_LAST_IDX_64 = 4'(LEB_MAX_BYTES_64 - 1);

  // Decoder state encodings.
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  // Last legal byte index for the selected target width.
  function automatic logic [3:0] leb_last_idx(input logic is64);
    logic [3:0] idx;
    if (is64) begin
      idx = LEB_LAST_IDX_64;
    end else begin
      idx = LEB_LAST_IDX_32;
    end
    return idx;
  endfunction

endpackage

// File: rtl/leb128_final_check.sv
// -----------------------------------------------------------------------------
// leb128_final_check
// Combinational legality check for a byte of an LEB128 stream. Bytes before the
// last legal index are always fine. At the last legal index the byte must
// terminate the value and its bits above the target width must be a pure
// zero-extension (unsigned) or sign-extension (signed) of the value.
//
// Ports:
//   data_byte  in  8  byte being accepted (bit 7 = continuation)
//   is_signed  in  1  1 = SLEB128, 0 = ULEB128
//   is64       in  1  1 = 64-bit target, 0 = 32-bit target
//   count      in  4  0-based index of data_byte within the value
//   ok         out 1  1 = byte is legal at this position
// -----------------------------------------------------------------------------
module leb128_final_check
  import leb128_pkg::*;
(
  input  logic [7:0] data_byte,
  input  logic       is_signed,
  input  logic       is64,
  input  logic [3:0] count,
  output logic       ok
);

  // Legality of the byte; only the last legal index is constrained.
  always_comb begin
    ok = 1'b1;
    if (count == leb_last_idx(is64)) begin
      if (data_byte[7]) begin
        // A continuation at the last legal index would overflow the target.
        ok = 1'b0;
      end else begin
        case ({is64, is_signed})
          // 32-bit target uses 4 payload bits of byte 4 (bits 28..31).
          2'b00:   ok = (data_byte[6:4] == 3'b000);
          2'b01:   ok = (data_byte[6:4] == {3{data_byte[3]}});
          // 64-bit target uses 1 payload bit of byte 9 (bit 63).
          2'b10:   ok = (data_byte[6:1] == 6'b000000);
          2'b11:   ok = (data_byte[6:1] == {6{data_byte[0]}});
          default: ok = 1'b0;
        endcase
      end
    end else begin
      ok = 1'b1;
    end
  end

endmodule

// File: rtl/leb128_decoder.sv
// -----------------------------------------------------------------------------
// leb128_decoder
// Streaming LEB128 immediate decoder feeding the cpu execute stage. Accepts one
// byte per cycle while accumulating, then presents the decoded 64-bit operand
// (or a malformed-encoding flag) until the consumer takes it.
//
// Ports:
//   clk        in  1   clock
//   reset      in  1   synchronous active-high reset
//   in_valid   in  1   in_data holds a byte
//   in_ready   out 1   byte accepted this cycle when in_valid is high
//   in_data    in  8   LEB128 byte, bit 7 = continuation
//   in_signed  in  1   1 = SLEB128 (sampled with the first byte)
//   in_is64    in  1   1 = 64-bit target (sampled with the first byte)
//   out_valid  out 1   decoded result available
//   out_ready  in  1   consumer takes the result
//   out_value  out 64  decoded value (0 on error)
//   out_len    out 4   bytes consumed, 1..10
//   out_error  out 1   encoding malformed
// -----------------------------------------------------------------------------
module leb128_decoder
  import leb128_pkg::*;
#(
  parameter int DATA_W = LEB_DATA_W
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_signed,
  input  logic              in_is64,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [3:0]        out_len,
  output logic              out_error
);

  logic [0:0]        state_q,     state_d;
  logic [DATA_W-1:0] acc_q,       acc_d;
  logic [3:0]        count_q,     count_d;
  logic              signed_q,    signed_d;
  logic              is64_q,      is64_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [3:0]        out_len_q,   out_len_d;
  logic              out_error_q, out_error_d;

  logic              mode_signed_s;
  logic              mode_is64_s;
  logic [6:0]        shamt_s;
  logic [6:0]        nbits_s;
  logic [6:0]        target_w_s;
  logic [DATA_W-1:0] acc_next_s;
  logic [DATA_W-1:0] result_s;
  logic              at_last_s;
  logic              final_ok_s;

  // Mode applies from the first byte; later bytes reuse the latched mode.
  assign mode_signed_s = (count_q == 4'd0) ? in_signed : signed_q;
  assign mode_is64_s   = (count_q == 4'd0) ? in_is64   : is64_q;

  leb128_final_check u_final_check (
    .data_byte (in_data),
    .is_signed (mode_signed_s),
    .is64      (mode_is64_s),
    .count     (count_q),
    .ok        (final_ok_s)
  );

  // Byte accumulation, result formation and the ACCUM/DONE handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    signed_d    = signed_q;
    is64_d      = is64_q;
    out_value_d = out_value_q;
    out_len_d   = out_len_q;
    out_error_d = out_error_q;

    shamt_s    = 7'(count_q) * 7'd7;
    nbits_s    = shamt_s + 7'd7;
    target_w_s = mode_is64_s ? 7'd64 : 7'd32;
    acc_next_s = acc_q | (DATA_W'(in_data[6:0]) << shamt_s);
    at_last_s  = (count_q == leb_last_idx(mode_is64_s));

    // Sign-extend only when the encoding stops short of the target width;
    // a full-length encoding already carries every bit explicitly.
    if (mode_signed_s && in_data[6] && (nbits_s < target_w_s)) begin
      result_s = acc_next_s | ({DATA_W{1'b1}} << nbits_s);
    end else begin
      result_s = acc_next_s;
    end

    // 32-bit results are zero-extended to the stack word.
    if (!mode_is64_s) begin
      result_s = result_s & {{(DATA_W-32){1'b0}}, {32{1'b1}}};
    end else begin
      result_s = result_s;
    end

    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          signed_d = mode_signed_s;
          is64_d   = mode_is64_s;
          acc_d    = acc_next_s;
          count_d  = count_q + 4'd1;
          if (!in_data[7] || at_last_s) begin
            state_d   = ST_DONE;
            out_len_d = count_q + 4'd1;
            if (final_ok_s) begin
              out_value_d = result_s;
              out_error_d = 1'b0;
            end else begin
              out_value_d = '0;
              out_error_d = 1'b1;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          count_d = 4'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        count_d = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= 4'd0;
      signed_q    <= 1'b0;
      is64_q      <= 1'b0;
      out_value_q <= '0;
      out_len_q   <= 4'd0;
      out_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      signed_q    <= signed_d;
      is64_q      <= is64_d;
      out_value_q <= out_value_d;
      out_len_q   <= out_len_d;
      out_error_q <= out_error_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_value = out_value_q;
  assign out_len   = out_len_q;
  assign out_error = out_error_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// -----------------------------------------------------------------------------
// tb_leb128_decoder
// Self-checking bench for leb128_decoder. Expected results come from an
// arithmetic reference: the encoding is summed into a wide integer, signed
// values are reinterpreted as two's complement of their encoded bit length,
// and legality is a length limit plus a numeric range check on the target.
// -----------------------------------------------------------------------------
module tb_leb128_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_signed;
  logic        in_is64;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  leb128_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_is64   (in_is64),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_len   (out_len),
    .out_error (out_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference decode: value, bytes consumed and error flag.
  function automatic void ref_decode(input logic [7:0] b[$], input logic sgn, input logic w64,
                                     output logic [63:0] val, output int len, output logic err);
    logic [127:0]        u;
    logic signed [127:0] v;
    logic signed [127:0] lim;
    int                  maxb;
    int                  width;
    logic                term;
    maxb  = w64 ? 10 : 5;
    width = w64 ? 64 : 32;
    u     = '0;
    len   = 0;
    term  = 1'b0;
    err   = 1'b0;
    val   = '0;
    for (int i = 0; i < b.size() && i < maxb && !term; i++) begin
      u    = u + (128'(b[i][6:0]) << (7 * i));
      len  = i + 1;
      term = !b[i][7];
    end
    if (!term) begin
      err = 1'b1;
    end else begin
      v = $signed(u);
      if (sgn && u[7*len-1]) v = v - (128'sd1 <<< (7 * len));
      if (sgn) begin
        lim = 128'sd1 <<< (width - 1);
        err = !((v >= -lim) && (v < lim));
      end else begin
        lim = 128'sd1 <<< width;
        err = !(v < lim);
      end
    end
    if (!err) begin
      if (w64) val = v[63:0];
      else     val = {32'd0, v[31:0]};
    end
  endfunction

  // A final byte at the last index whose high bits extend the value legally.
  function automatic logic [7:0] legal_last(input logic s, input logic w);
    logic [7:0] r;
    r = 8'($urandom);
    if (!s) r = w ? (r & 8'h01) : (r & 8'h0F);
    else if (w) r = r[0] ? 8'h7F : 8'h00;
    else r = r[3] ? ((r | 8'h78) & 8'h7F) : (r & 8'h07);
    return r;
  endfunction

  // Drive one value, check the result and its hold/handshake behaviour.
  task automatic run_value(input string tag, input logic [7:0] b[$], input logic sgn,
                           input logic w64, input int hold, input bit gaps);
    logic [63:0] ev;
    int          elen;
    logic        eerr;
    ref_decode(b, sgn, w64, ev, elen, eerr);
    for (int i = 0; i < elen; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = b[i];
      if (i == 0) begin
        in_signed = sgn;
        in_is64   = w64;
      end else begin
        in_signed = 1'($urandom);
        in_is64   = 1'($urandom);
      end
      check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
      check_eq({tag, " early_valid"}, 64'(out_valid), 64'd0);
      tick();
    end
    // A byte beyond the value stays presented but must not be taken.
    if (b.size() > elen) begin
      in_valid = 1'b1;
      in_data  = b[elen];
    end else begin
      in_valid = 1'b0;
    end
    check_eq({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, " out_value"}, out_value, ev);
    check_eq({tag, " out_len"}, 64'(out_len), 64'(elen));
    check_eq({tag, " out_error"}, 64'(out_error), 64'(eerr));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      check_eq({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
      tick();
      check_eq({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, " hold_value"}, out_value, ev);
      check_eq({tag, " hold_len"}, 64'(out_len), 64'(elen));
    end
    out_ready = 1'b1;
    check_eq({tag, " release_in_ready"}, 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq({tag, " bubble_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, " bubble_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] q[$];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_signed = 1'b0;
    in_is64   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset out_value", out_value, 64'd0);
    check_eq("reset out_len", 64'(out_len), 64'd0);
    check_eq("reset out_error", 64'(out_error), 64'd0);
    check_eq("reset in_ready", 64'(in_ready), 64'd1);

    q = '{8'h2A};                               run_value("u32_42", q, 1'b0, 1'b0, 0, 1'b0);
    q = '{8'hE5, 8'h8E, 8'h26};                 run_value("u32_624485", q, 1'b0, 1'b0, 1, 1'b0);
    q = '{8'h7F};                               run_value("s32_m1", q, 1'b1, 1'b0, 0, 1'b0);
    q = '{8'hC0, 8'hBB, 8'h78};                 run_value("s64_m123456", q, 1'b1, 1'b1, 0, 1'b0);
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};   run_value("u32_max", q, 1'b0, 1'b0, 0, 1'b0);
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};   run_value("u32_ovf", q, 1'b0, 1'b0, 0, 1'b0);
    q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
    run_value("u32_toolong", q, 1'b0, 1'b0, 2, 1'b0);
    q = '{8'h2A, 8'h01};                        run_value("bp_first", q, 1'b0, 1'b0, 3, 1'b0);
    q = '{8'h01};                               run_value("bp_second", q, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of a value discards the partial accumulation.
    in_valid  = 1'b1;
    in_signed = 1'b0;
    in_is64   = 1'b0;
    in_data   = 8'hE5;
    tick();
    in_data = 8'h8E;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midreset out_valid", 64'(out_valid), 64'd0);
    check_eq("midreset out_value", out_value, 64'd0);
    check_eq("midreset out_len", 64'(out_len), 64'd0);
    check_eq("midreset out_error", 64'(out_error), 64'd0);
    check_eq("midreset in_ready", 64'(in_ready), 64'd1);
    q = '{8'h05};                               run_value("after_reset", q, 1'b0, 1'b0, 0, 1'b0);

    for (int it = 0; it < 300; it++) begin
      logic       s;
      logic       w;
      int         maxb;
      int         n;
      logic [7:0] bb;
      s    = 1'($urandom);
      w    = 1'($urandom);
      maxb = w ? 10 : 5;
      n    = ($urandom_range(0, 7) == 0) ? (maxb + 1) : int'($urandom_range(1, maxb));
      q.delete();
      for (int i = 0; i < n; i++) begin
        bb = 8'($urandom);
        if (n > maxb) begin
          if (i < maxb) bb[7] = 1'b1;
        end else if (i < n - 1) begin
          bb[7] = 1'b1;
        end else begin
          bb[7] = 1'b0;
          if (i == maxb - 1 && $urandom_range(0, 1) == 1) bb = legal_last(s, w);
        end
        q.push_back(bb);
      end
      run_value("rand", q, s, w, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
